// File: rtl/prio_enc_rr.sv
// N-to-log2(N) priority encoder with registered outputs.
// MODE=0: fixed priority, highest index wins.
// MODE=1: round-robin; search starts at ptr and ptr moves just past each grant.
module prio_enc_rr #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] D,
  output logic [W-1:0] Q,
  output logic [N-1:0] grant,
  output logic         valid,
  output logic         multi
);

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic [W-1:0] ptr, ptr_d;
  logic [W-1:0] k_fix, k_rr, k, off;
  logic [N-1:0] rot, grant_d;
  logic [W:0]   sum;
  logic         multi_d;

  // Fixed priority: highest set index wins, so the last hit in an ascending scan.
  always_comb begin
    k_fix = '0;
    for (int i = 0; i < N; i++)
      if (D[i]) k_fix = W'(i);
  end

  // Round-robin: rotate D so bit ptr lands at bit 0, take the lowest set bit,
  // then map the offset back with an explicit mod-N add (N need not be 2^W).
  always_comb begin
    rot = N'({D, D} >> ptr);
    off = '0;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) off = W'(j);
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    k_rr = sum[W-1:0];
  end

  // Select the winner for the configured mode and derive the next-state values.
  always_comb begin
    k       = (MODE == 1) ? k_rr : k_fix;
    grant_d = ONE_N << k;
    multi_d = |(D & (D - ONE_N));
    ptr_d   = '0;
    if (MODE == 1)
      ptr_d = (k == W'(N - 1)) ? '0 : k + W'(1);
  end

  // Output and pointer registers; everything holds while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q     <= '0;
      grant <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
      ptr   <= '0;
    end else if (en) begin
      if (|D) begin
        Q     <= k;
        grant <= grant_d;
        valid <= 1'b1;
        multi <= multi_d;
        ptr   <= ptr_d;
      end else begin
        Q     <= '0;
        grant <= '0;
        valid <= 1'b0;
        multi <= 1'b0;
      end
    end
  end

endmodule
